// File: rtl/riscv_io_rx.sv
// riscv_io_rx: memory-mapped console input for the core.
// Host bytes are queued in a FIFO and read back through load/status registers.
module riscv_io_rx #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] ADDR_DATA = 32'h8000_0004,
  parameter logic [31:0] ADDR_STAT = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_unf;

  logic w_full;
  logic w_empty;
  logic w_hit_data;
  logic w_hit_stat;
  logic w_push;
  logic w_pop;
  logic w_unf_set;
  logic w_unf_clr;
  logic w_unused;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_hit_data = (a == ADDR_DATA);
  assign w_hit_stat = (a == ADDR_STAT);
  assign in_ready   = !rst && !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = re && w_hit_data && !w_empty;
  assign w_unf_set  = re && w_hit_data && w_empty;
  assign w_unf_clr  = we && w_hit_stat && wd[2];
  assign sel        = w_hit_data || w_hit_stat;
  assign w_unused   = ^{wd[31:3], wd[1:0]};

  // Byte storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Pointers, occupancy and sticky underflow (set has priority over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (w_unf_clr) begin
        r_unf <= 1'b0;
      end
    end
  end

  // Read mux: head byte or status word, zero elsewhere.
  always_comb begin
    rd = 32'h0;
    if (w_hit_data && !w_empty) begin
      rd = {24'h0, r_mem[r_rptr]};
    end else if (w_hit_stat) begin
      rd = {16'h0, 8'(r_count), 5'h0, r_unf, w_full, !w_empty};
    end
  end

endmodule

// File: tb/tb_riscv_io_rx.sv
// tb_riscv_io_rx: directed checks plus a scoreboarded mixed
// push/pop run for the console receive port.
module tb_riscv_io_rx;

  localparam logic [31:0] AD = 32'h8000_0004;
  localparam logic [31:0] AS = 32'h8000_0008;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] a;
  logic        re;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;

  int n_cmp;
  int n_bad;

  logic [7:0] q[$];
  bit         unf;

  riscv_io_rx dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .a       (a),
    .re      (re),
    .we      (we),
    .wd      (wd),
    .rd      (rd),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat_of(input int c, input bit u);
    return {16'h0, 8'(c), 5'h0, u, c == 16, c != 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stat(input string tag, input logic [31:0] exp);
    a = AS;
    #1;
    check(tag, rd, exp);
    a = 32'h0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    a  = AD;
    re = 1'b1;
    #1;
    check(tag, rd, {24'h0, exp});
    tick();
    re = 1'b0;
    a  = 32'h0;
  endtask

  task automatic clr_unf();
    a  = AS;
    we = 1'b1;
    wd = 32'h4;
    tick();
    we = 1'b0;
    wd = 32'h0;
    a  = 32'h0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h0;
    a        = 32'h0;
    re       = 1'b0;
    we       = 1'b0;
    wd       = 32'h0;

    tick();
    tick();
    check("rst_rdy", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rdy", 32'(in_ready), 32'h1);
    stat("rst_stat", 32'h0);
    a = AD;
    #1;
    check("rst_data", rd, 32'h0);
    check("sel_data", 32'(sel), 32'h1);
    a = 32'h1234;
    #1;
    check("sel_other", 32'(sel), 32'h0);
    check("rd_other", rd, 32'h0);
    a = 32'h0;

    push(8'h48);
    push(8'h69);
    stat("hi_stat", 32'h0000_0201);
    pop("pop_H", 8'h48);
    pop("pop_i", 8'h69);
    stat("hi_empty", 32'h0);

    for (int i = 0; i < 16; i++) push(8'(i));
    check("full_rdy", 32'(in_ready), 32'h0);
    stat("full_stat", 32'h0000_1003);
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    stat("hold_stat", 32'h0000_1003);
    a  = AD;
    re = 1'b1;
    #1;
    check("fpop_rd", rd, 32'h0);
    check("fpop_rdy", 32'(in_ready), 32'h0);
    tick();
    re = 1'b0;
    a  = 32'h0;
    check("refill_rdy", 32'(in_ready), 32'h1);
    stat("after_pop", 32'h0000_0F03 & 32'hFFFF_FFFD | 32'h0);
    tick();
    in_valid = 1'b0;
    stat("refull", 32'h0000_1003);
    for (int i = 1; i < 17; i++) pop("drain", 8'(i));
    stat("drained", 32'h0);

    pop("empty_rd", 8'h00);
    stat("unf_set", 32'h4);
    clr_unf();
    stat("unf_clr", 32'h0);

    in_valid = 1'b1;
    in_data  = 8'h55;
    a        = AD;
    re       = 1'b1;
    #1;
    check("ep_rd", rd, 32'h0);
    tick();
    in_valid = 1'b0;
    re       = 1'b0;
    a        = 32'h0;
    stat("ep_stat", 32'h0000_0105);
    clr_unf();

    in_valid = 1'b1;
    in_data  = 8'h66;
    a        = AD;
    re       = 1'b1;
    #1;
    check("pp_rd", rd, 32'h55);
    tick();
    in_valid = 1'b0;
    re       = 1'b0;
    a        = 32'h0;
    stat("pp_stat", 32'h0000_0101);
    pop("pp_next", 8'h66);

    unf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit         dp;
      bit         dq;
      int         n;
      logic [7:0] b;
      dp = ($urandom_range(0, 2) != 0);
      dq = ($urandom_range(0, 1) != 0);
      b  = 8'($urandom);
      n  = q.size();
      in_valid = dp;
      in_data  = b;
      re       = dq;
      a        = dq ? AD : 32'h0;
      #1;
      check("mix_rdy", 32'(in_ready), 32'(n < 16));
      if (dq) check("mix_rd", rd, n > 0 ? {24'h0, q[0]} : 32'h0);
      tick();
      if (dq && n > 0) void'(q.pop_front());
      if (dq && n == 0) unf = 1'b1;
      if (dp && n < 16) q.push_back(b);
    end
    in_valid = 1'b0;
    re       = 1'b0;
    a        = 32'h0;
    stat("mix_stat", stat_of(q.size(), unf));
    while (q.size() > 0) pop("mix_drain", q.pop_front());
    clr_unf();
    stat("mix_end", 32'h0);

    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    stat("pre_rst", 32'h0000_0501);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    a        = AD;
    re       = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    re       = 1'b0;
    a        = 32'h0;
    stat("rst_mid", 32'h0);
    push(8'hA1);
    push(8'hA2);
    pop("new_1", 8'hA1);
    pop("new_2", 8'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
